// File: rtl/seg7_capture.sv
// Collects active-low seven-segment digit patterns into a DIGITS-wide BCD result.
// Hands the result or a decode error to the consumer and holds it until out_ack.
module seg7_capture #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    input  logic                  clear,
    input  logic                  out_ack,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  err,
    output logic [2:0]            digit_count
);

    localparam int unsigned BCD_W      = 4 * DIGITS;
    localparam logic [2:0]  LAST_COUNT = 3'(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic [2:0]         count_q, count_d;

    logic [3:0]         digit_c;
    logic               digit_ok_c;
    logic [BCD_W-1:0]   acc_shift_c;
    logic [2:0]         count_inc_c;

    // Pattern decoder; anything outside the ten digit shapes is rejected.
    always_comb begin
        digit_c    = 4'd0;
        digit_ok_c = 1'b1;
        case (seg_in)
            7'b1000000: digit_c = 4'd0;
            7'b1111001: digit_c = 4'd1;
            7'b0100100: digit_c = 4'd2;
            7'b0110000: digit_c = 4'd3;
            7'b0011001: digit_c = 4'd4;
            7'b0010010: digit_c = 4'd5;
            7'b0000010: digit_c = 4'd6;
            7'b1111000: digit_c = 4'd7;
            7'b0000000: digit_c = 4'd8;
            7'b0010000: digit_c = 4'd9;
            default:    digit_ok_c = 1'b0;
        endcase
    end

    // Truncating the concatenation drops the oldest nibble and works for DIGITS=1.
    assign acc_shift_c = BCD_W'({acc_q, digit_c});
    assign count_inc_c = 3'(count_q + 3'd1);

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        err_d   = err_q;
        count_d = count_q;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (clear) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    count_d = 3'd0;
                end else if (seg_valid) begin
                    if (!digit_ok_c) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        acc_d   = '0;
                        count_d = 3'd0;
                    end else begin
                        acc_d   = acc_shift_c;
                        count_d = count_inc_c;
                        if (count_inc_c == LAST_COUNT) begin
                            state_d = S_DONE;
                            bcd_d   = acc_shift_c;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (out_ack) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    count_d = 3'd0;
                    acc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign seg_ready   = ready_q;
    assign bcd_out     = bcd_q;
    assign out_valid   = valid_q;
    assign err         = err_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios on a 2-digit instance, a full pattern
// sweep on a 1-digit instance, and randomized traffic against a queue-based model.
module tb_seg7_capture;

    logic       clk;
    int         total;
    int         bad;

    // DIGITS=2 instance
    logic       rst, sv, clr, ack;
    logic [6:0] seg;
    logic       rdy, ov, er;
    logic [7:0] bcd;
    logic [2:0] cnt;

    // DIGITS=1 instance
    logic       rst1, sv1, clr1, ack1;
    logic [6:0] seg1;
    logic       rdy1, ov1, er1;
    logic [3:0] bcd1;
    logic [2:0] cnt1;

    seg7_capture #(.DIGITS(2)) dut (
        .clk(clk), .reset(rst), .seg_in(seg), .seg_valid(sv), .seg_ready(rdy),
        .clear(clr), .out_ack(ack), .bcd_out(bcd), .out_valid(ov), .err(er),
        .digit_count(cnt)
    );

    seg7_capture #(.DIGITS(1)) dut1 (
        .clk(clk), .reset(rst1), .seg_in(seg1), .seg_valid(sv1), .seg_ready(rdy1),
        .clear(clr1), .out_ack(ack1), .bcd_out(bcd1), .out_valid(ov1), .err(er1),
        .digit_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_pattern(input int d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic int ref_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++)
            if (ref_pattern(d) == p) return d;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        tick();
        rst = 1'b0; rst1 = 1'b0;
        total++;
        if ({rdy, ov, er, bcd, cnt} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
            bad++;
            $display("FAIL reset2 got rdy=%b ov=%b err=%b bcd=%h cnt=%0d exp 1 0 0 00 0", rdy, ov, er, bcd, cnt);
        end
        total++;
        if ({rdy1, ov1, er1, bcd1, cnt1} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'd0}) begin
            bad++;
            $display("FAIL reset1 got rdy=%b ov=%b err=%b bcd=%h cnt=%0d exp 1 0 0 0 0", rdy1, ov1, er1, bcd1, cnt1);
        end
    endtask

    task automatic test_basic();
        sv = 1'b1; seg = 7'b0100100;
        tick();
        total++;
        if (cnt !== 3'd1 || rdy !== 1'b1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL basic_first got cnt=%0d rdy=%b ov=%b exp 1 1 0", cnt, rdy, ov);
        end
        seg = 7'b0010000;
        tick();
        sv = 1'b0;
        total++;
        if (ov !== 1'b1 || bcd !== 8'h29 || rdy !== 1'b0 || cnt !== 3'd2 || er !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got ov=%b bcd=%h rdy=%b cnt=%0d err=%b exp 1 29 0 2 0", ov, bcd, rdy, cnt, er);
        end
        tick();
        total++;
        if (rdy !== 1'b0 || ov !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold got rdy=%b ov=%b exp 0 1", rdy, ov);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (ov !== 1'b0 || cnt !== 3'd0 || rdy !== 1'b1 || bcd !== 8'h29) begin
            bad++;
            $display("FAIL basic_ack got ov=%b cnt=%0d rdy=%b bcd=%h exp 0 0 1 29", ov, cnt, rdy, bcd);
        end
    endtask

    task automatic test_error();
        sv = 1'b1; seg = 7'b1111001;
        tick();
        seg = 7'b1111111;
        tick();
        sv = 1'b0;
        total++;
        if (er !== 1'b1 || ov !== 1'b0 || bcd !== 8'h29 || cnt !== 3'd0 || rdy !== 1'b0) begin
            bad++;
            $display("FAIL error_set got err=%b ov=%b bcd=%h cnt=%0d rdy=%b exp 1 0 29 0 0", er, ov, bcd, cnt, rdy);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (er !== 1'b0 || cnt !== 3'd0 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL error_ack got err=%b cnt=%0d rdy=%b exp 0 0 1", er, cnt, rdy);
        end
    endtask

    task automatic test_clear();
        sv = 1'b1; seg = 7'b0011001;
        tick();
        clr = 1'b1; seg = 7'b1111000;
        tick();
        clr = 1'b0;
        total++;
        if (cnt !== 3'd0 || rdy !== 1'b1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL clear_prio got cnt=%0d rdy=%b ov=%b exp 0 1 0", cnt, rdy, ov);
        end
        seg = 7'b0110000;
        tick();
        seg = 7'b1000000;
        tick();
        sv = 1'b0;
        total++;
        if (bcd !== 8'h30 || ov !== 1'b1) begin
            bad++;
            $display("FAIL clear_next got bcd=%h ov=%b exp 30 1", bcd, ov);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (ov !== 1'b1 || cnt !== 3'd2) begin
            bad++;
            $display("FAIL clear_in_done got ov=%b cnt=%0d exp 1 2", ov, cnt);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_hold_in_done();
        sv = 1'b1; seg = 7'b1111001;
        tick();
        seg = 7'b0100100;
        tick();
        seg = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cnt !== 3'd2 || ov !== 1'b1 || bcd !== 8'h12 || rdy !== 1'b0) begin
                bad++;
                $display("FAIL hold_done[%0d] got cnt=%0d ov=%b bcd=%h rdy=%b exp 2 1 12 0", i, cnt, ov, bcd, rdy);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (cnt !== 3'd0 || ov !== 1'b0 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL hold_ack got cnt=%0d ov=%b rdy=%b exp 0 0 1", cnt, ov, rdy);
        end
        tick();
        sv = 1'b0;
        total++;
        if (cnt !== 3'd1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL hold_accept got cnt=%0d ov=%b exp 1 0", cnt, ov);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; ack = 1'b1; clr = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0; clr = 1'b0;
        total++;
        if ({rdy, ov, er, bcd, cnt} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'd0}) begin
            bad++;
            $display("FAIL reset_mid got rdy=%b ov=%b err=%b bcd=%h cnt=%0d exp 1 0 0 00 0", rdy, ov, er, bcd, cnt);
        end
        sv = 1'b1; seg = 7'b0010010;
        tick();
        seg = 7'b0000010;
        tick();
        sv = 1'b0;
        total++;
        if (bcd !== 8'h56 || ov !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_next got bcd=%h ov=%b exp 56 1", bcd, ov);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_sweep();
        int         n_ok;
        int         d;
        logic [3:0] last_good;
        n_ok = 0;
        last_good = 4'h0;
        for (int v = 0; v < 128; v++) begin
            sv1 = 1'b1; seg1 = 7'(v);
            tick();
            sv1 = 1'b0;
            d = ref_decode(7'(v));
            if (d >= 0) last_good = 4'(d);
            if (ov1 === 1'b1) n_ok++;
            total++;
            if (ov1 !== (d >= 0) || er1 !== (d < 0) || bcd1 !== last_good || rdy1 !== 1'b0) begin
                bad++;
                $display("FAIL sweep[%b] got ov=%b err=%b bcd=%h rdy=%b exp ov=%b err=%b bcd=%h rdy=0",
                         7'(v), ov1, er1, bcd1, rdy1, d >= 0, d < 0, last_good);
            end
            ack1 = 1'b1;
            tick();
            ack1 = 1'b0;
        end
        total++;
        if (n_ok !== 10) begin
            bad++;
            $display("FAIL sweep_count got %0d valid patterns exp 10", n_ok);
        end
    endtask

    task automatic test_random();
        int         phase;      // 0 accepting, 1 result held, 2 error held
        int         digs[$];
        logic [7:0] m_bcd;
        bit         m_ov, m_err;
        int         d;
        int         val;
        logic [2:0] m_cnt;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        phase = 0; digs.delete(); m_bcd = 8'h00; m_ov = 1'b0; m_err = 1'b0;

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 3) == 0);
            sv  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) seg = ref_pattern(int'($urandom_range(0, 9)));
            else                           seg = 7'($urandom_range(0, 127));

            if (rst) begin
                phase = 0; digs.delete(); m_bcd = 8'h00; m_ov = 1'b0; m_err = 1'b0;
            end else if (phase == 0) begin
                if (clr) begin
                    digs.delete();
                end else if (sv) begin
                    d = ref_decode(seg);
                    if (d < 0) begin
                        phase = 2; m_err = 1'b1; digs.delete();
                    end else begin
                        digs.push_back(d);
                        if (digs.size() == 2) begin
                            val = 0;
                            foreach (digs[k]) val = val * 16 + digs[k];
                            m_bcd = 8'(val);
                            m_ov  = 1'b1;
                            phase = 1;
                        end
                    end
                end
            end else if (ack) begin
                phase = 0; m_ov = 1'b0; m_err = 1'b0; digs.delete();
            end
            m_cnt = 3'(digs.size());

            tick();
            total++;
            if (rdy !== (phase == 0) || ov !== m_ov || er !== m_err || bcd !== m_bcd || cnt !== m_cnt
                || (ov === 1'b1 && er === 1'b1)) begin
                bad++;
                $display("FAIL random[%0d] got rdy=%b ov=%b err=%b bcd=%h cnt=%0d exp rdy=%b ov=%b err=%b bcd=%h cnt=%0d",
                         c, rdy, ov, er, bcd, cnt, phase == 0, m_ov, m_err, m_bcd, m_cnt);
            end
        end
        rst = 1'b0; clr = 1'b0; ack = 1'b0; sv = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; sv = 1'b0; clr = 1'b0; ack = 1'b0; seg = 7'h7f;
        rst1 = 1'b1; sv1 = 1'b0; clr1 = 1'b0; ack1 = 1'b0; seg1 = 7'h7f;
        tick();
        test_reset();
        test_basic();
        test_error();
        test_clear();
        test_hold_in_done();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter DIGITS, default 2, number of decimal digits assembled per result; legal range 1..6.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment pattern; bit 6 = segment g, bit 0 = segment a.
REQ-005 seg_valid  input  1  seg_in holds a pattern offered for transfer.
REQ-006 seg_ready  output  1  block can accept a pattern this cycle.
REQ-007 clear  input  1  discard the partial result and return to IDLE.
REQ-008 out_ack  input  1  consumer acknowledges the result or the error.
REQ-009 bcd_out  output  4*DIGITS  assembled BCD result, most significant digit in the top nibble.
REQ-010 out_valid  output  1  bcd_out holds a complete new result.
REQ-011 err  output  1  an undecodable pattern was received.
REQ-012 digit_count  output  3  digits accepted in the current result.

Function
REQ-013 A transfer occurs on a rising edge with seg_valid=1 and seg_ready=1; no transfer occurs otherwise.
REQ-014 Decode table (seg_in -> digit):
- 1000000 -> 0, 1111001 -> 1, 0100100 -> 2, 0110000 -> 3, 0011001 -> 4
- 0010010 -> 5, 0000010 -> 6, 1111000 -> 7, 0000000 -> 8, 0010000 -> 9
- Every other pattern, including all-blank 1111111, is invalid.
REQ-015 The block has four states, IDLE, COLLECT, DONE and ERROR, with seg_ready=1 exactly in IDLE and COLLECT.
REQ-016 A valid transfer shifts the internal accumulator left by one nibble, inserts the new digit in the low nibble and increments digit_count, so the first digit received becomes the most significant.
REQ-017 In IDLE, a valid transfer goes to COLLECT, or to DONE when DIGITS=1.
REQ-018 In COLLECT, the valid transfer that brings digit_count to DIGITS goes to DONE, with both effects on that same edge:
- the accumulator is copied to bcd_out;
- out_valid=1 from the next cycle (one-cycle latency from the final transfer).
REQ-019 A transfer of an invalid pattern in IDLE or COLLECT goes to ERROR, with these effects:
- err=1;
- the accumulator and digit_count are zeroed;
- bcd_out retains its previous value.
REQ-020 DONE and ERROR persist until out_ack=1; that edge moves to IDLE and clears out_valid, err and digit_count.
REQ-021 out_ack is ignored in IDLE and COLLECT.
REQ-022 clear=1 in IDLE or COLLECT goes to IDLE, zeroing the accumulator and digit_count.
REQ-023 clear has priority over a simultaneous transfer; the digit is discarded.
REQ-024 clear is ignored in DONE and ERROR.
REQ-025 seg_valid offered while seg_ready=0 is not consumed; the producer holds the pattern until seg_ready=1.
REQ-026 out_valid and err are never both 1.
REQ-027 digit_count never exceeds DIGITS.

Reset
REQ-028 reset=1 on any edge, including mid-collection or in DONE or ERROR, sets:
- state IDLE;
- bcd_out=0, out_valid=0, err=0, digit_count=0;
- accumulator zero.
REQ-029 reset has priority over clear, out_ack and any transfer on the same edge.

Verification
REQ-030 DIGITS=2: transfer 0100100 then 0010000 on consecutive cycles -> bcd_out=8'h29, out_valid=1 one cycle after the second transfer, seg_ready=0 until out_ack.
REQ-031 Transfer 1111001 then 1111111 -> err=1, out_valid=0, bcd_out unchanged; out_ack -> IDLE, err=0, digit_count=0.
REQ-032 Transfer 0011001, then clear=1 with seg_valid=1 carrying 1111000 on the same edge -> IDLE, digit_count=0; a following sequence 0110000, 1000000 -> bcd_out=8'h30.
REQ-033 In DONE, hold seg_valid=1 with 0000000 for 3 cycles, then pulse out_ack -> no digit accepted while in DONE; the pattern is accepted on the first edge back in IDLE (digit_count=1).
REQ-034 reset=1 mid-collection after one digit -> all outputs zero, IDLE; the next two transfers 0010010, 0000010 -> bcd_out=8'h56.
REQ-035 Sweep all 128 seg_in values with DIGITS=1 -> exactly the 10 REQ-014 patterns set out_valid with the matching digit; the other 118 set err.
